// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle controller and its datapath
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5;
  logic Zero;
  logic PCWrite;
  logic AdrSrc;
  logic MemWrite;
  logic IRWrite;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUSrcA;
  logic [2:0] ImmSrc;
  logic RegWrite;
  logic retire;
  logic illegal_op;
  logic [31:0] instret;
  logic [3:0] state;
  modport master(
    input op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcB, ALUSrcA,
           ImmSrc, RegWrite, retire, illegal_op, instret, state
  );
  modport slave(
    output op, funct3, funct7b5, Zero,
    input PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcB, ALUSrcA,
          ImmSrc, RegWrite, retire, illegal_op, instret, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM with retire/illegal status and instret counter
module multicycle_controller (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC
  } state_t;
  state_t st, dec_next;
  logic retire_r, illegal_r, pc_update, irw, mw, rw, adr, taken;
  logic [31:0] instret_r;
  logic [2:0] func, alu, imm;
  logic [1:0] rs, asel, bsel;
  always_comb begin
    dec_next = FETCH;
    case (bus.op)
      7'b0000011, 7'b0100011: dec_next = MEMADR;
      7'b0110011: dec_next = EXECR;
      7'b0010011: dec_next = EXECI;
      7'b1100011: dec_next = BRANCH;
      7'b1101111: dec_next = JAL;
      7'b1100111: dec_next = JALR;
      7'b0110111: dec_next = LUI;
      7'b0010111: dec_next = AUIPC;
      default: dec_next = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= FETCH;
      retire_r <= 1'b0;
      illegal_r <= 1'b0;
      instret_r <= '0;
    end else begin
      retire_r <= st inside {MEMWB, MEMWRITE, ALUWB, BRANCH};
      illegal_r <= st == DECODE && dec_next == FETCH;
      if (st inside {MEMWB, MEMWRITE, ALUWB, BRANCH}) instret_r <= instret_r + 32'd1;
      case (st)
        FETCH: st <= DECODE;
        DECODE: st <= dec_next;
        MEMADR: st <= bus.op[5] ? MEMWRITE : MEMREAD;
        MEMREAD: st <= MEMWB;
        EXECR, EXECI, LUI, AUIPC, JAL: st <= ALUWB;
        JALR: st <= JAL;
        default: st <= FETCH;
      endcase
    end
  end
  assign func = bus.funct3 == 3'b000 ? ((bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000) :
                bus.funct3 == 3'b010 ? 3'b101 :
                bus.funct3 == 3'b110 ? 3'b011 :
                bus.funct3 == 3'b111 ? 3'b010 : 3'b000;
  assign taken = (bus.funct3 == 3'b000 && bus.Zero) || (bus.funct3 == 3'b001 && !bus.Zero);
  always_comb begin
    pc_update = 1'b0;
    irw = 1'b0;
    mw = 1'b0;
    rw = 1'b0;
    adr = 1'b0;
    rs = 2'b00;
    alu = 3'b000;
    asel = 2'b00;
    bsel = 2'b00;
    case (st)
      FETCH: begin irw = 1'b1; bsel = 2'b10; rs = 2'b10; pc_update = 1'b1; end
      DECODE: begin asel = 2'b01; bsel = 2'b01; end
      MEMADR: begin asel = 2'b10; bsel = 2'b01; end
      MEMREAD: adr = 1'b1;
      MEMWB: begin rs = 2'b01; rw = 1'b1; end
      MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      EXECR: begin asel = 2'b10; alu = func; end
      EXECI: begin asel = 2'b10; bsel = 2'b01; alu = func; end
      ALUWB: rw = 1'b1;
      BRANCH: begin asel = 2'b10; alu = 3'b001; end
      JAL: begin asel = 2'b01; bsel = 2'b10; pc_update = 1'b1; end
      JALR: begin asel = 2'b10; bsel = 2'b01; end
      LUI: begin asel = 2'b11; bsel = 2'b01; end
      AUIPC: begin asel = 2'b01; bsel = 2'b01; end
      default: ;
    endcase
  end
  always_comb begin
    imm = 3'b000;
    case (bus.op)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111, 7'b0010111: imm = 3'b100;
      default: imm = 3'b000;
    endcase
  end
  // write enables are gated by reset so an abandoned instruction cannot write
  assign bus.PCWrite = !reset && (pc_update || (st == BRANCH && taken));
  assign bus.IRWrite = !reset && irw;
  assign bus.MemWrite = !reset && mw;
  assign bus.RegWrite = !reset && rw;
  assign bus.AdrSrc = adr;
  assign bus.ResultSrc = rs;
  assign bus.ALUControl = alu;
  assign bus.ALUSrcA = asel;
  assign bus.ALUSrcB = bsel;
  assign bus.ImmSrc = imm;
  assign bus.retire = retire_r;
  assign bus.illegal_op = illegal_r;
  assign bus.instret = instret_r;
  assign bus.state = st;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench comparing per-cycle controls against an instruction-level model
module tb_multicycle_controller;
  typedef struct packed {
    logic [3:0] st;
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs;
    logic [2:0] alu;
    logic [1:0] a, b;
    logic [2:0] imm;
    logic ret, ill;
    logic [31:0] cnt;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  rec_t sb[$];
  logic mon_en = 1'b0;
  logic m_ret = 1'b0;
  logic m_ill = 1'b0;
  logic [31:0] m_cnt = '0;
  logic [1:0] a_tab [14] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [1:0] b_tab [14] = '{2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1};
  logic [6:0] ops [14] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111,
                           7'b0110111, 7'b0010111, 7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011, 7'b0100111};
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else begin
        rec_t e, d;
        e = sb.pop_front();
        d = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
             bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.retire, bus.illegal_op, bus.instret};
        check($sformatf("cycle_st%0d_op%b", e.st, bus.op), {9'b0, d}, {9'b0, e});
      end
    end
  end
  // Model: an instruction is a path of states; controls follow from the state plus instruction fields.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    int path[$];
    rec_t r;
    logic tk;
    logic [2:0] fn, im;
    int s;
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    bus.Zero = z;
    path.push_back(0);
    path.push_back(1);
    case (o)
      7'b0000011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      7'b0100011: begin path.push_back(2); path.push_back(5); end
      7'b0110011: begin path.push_back(6); path.push_back(8); end
      7'b0010011: begin path.push_back(7); path.push_back(8); end
      7'b1100011: path.push_back(9);
      7'b1101111: begin path.push_back(10); path.push_back(8); end
      7'b1100111: begin path.push_back(11); path.push_back(10); path.push_back(8); end
      7'b0110111: begin path.push_back(12); path.push_back(8); end
      7'b0010111: begin path.push_back(13); path.push_back(8); end
      default: ;
    endcase
    tk = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
    fn = f3 == 3'd0 ? ((o[5] && f7) ? 3'd1 : 3'd0) : f3 == 3'd2 ? 3'd5 : f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd2 : 3'd0;
    im = o == 7'b0100011 ? 3'd1 : o == 7'b1100011 ? 3'd2 : o == 7'b1101111 ? 3'd3 :
         (o == 7'b0110111 || o == 7'b0010111) ? 3'd4 : 3'd0;
    foreach (path[i]) begin
      s = path[i];
      r = '0;
      r.st = 4'(s);
      r.pcw = s == 0 || s == 10 || (s == 9 && tk);
      r.adr = s == 3 || s == 5;
      r.mw = s == 5;
      r.irw = s == 0;
      r.rw = s == 4 || s == 8;
      r.rs = s == 0 ? 2'd2 : s == 4 ? 2'd1 : 2'd0;
      r.alu = s == 9 ? 3'd1 : (s == 6 || s == 7) ? fn : 3'd0;
      r.a = a_tab[s];
      r.b = b_tab[s];
      r.imm = im;
      r.ret = i == 0 && m_ret;
      r.ill = i == 0 && m_ill;
      r.cnt = m_cnt;
      sb.push_back(r);
    end
    repeat (path.size()) @(posedge clk);
    #1;
    s = path[path.size() - 1];
    m_ret = s == 4 || s == 5 || s == 8 || s == 9;
    m_ill = s == 1;
    if (m_ret) m_cnt = m_cnt + 32'd1;
  endtask
  initial begin
    bus.op = '0;
    bus.funct3 = '0;
    bus.funct7b5 = 1'b0;
    bus.Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {60'b0, bus.state}, 64'd0);
    check("rst_wen", {60'b0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 64'd0);
    check("rst_instret", {32'b0, bus.instret}, 64'd0);
    check("rst_fetch_sel", {58'b0, bus.ALUSrcB, bus.ResultSrc, bus.ALUSrcA}, {58'b0, 2'd2, 2'd2, 2'd0});
    reset = 1'b0;
    mon_en = 1'b1;
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);
    run_instr(7'b0110011, 3'd6, 1'b0, 1'b0);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b1);
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b0);
    run_instr(7'b1100111, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0110111, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0);
    check("instret_after_directed", {32'b0, bus.instret}, {32'b0, m_cnt});
    for (int n = 0; n < 200; n++)
      run_instr(ops[$urandom_range(0, 13)], 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
    // preload the counter just below wrap; it only changes again on the next retire
    force dut.instret_r = 32'hFFFF_FFFF;
    #1;
    release dut.instret_r;
    m_cnt = 32'hFFFF_FFFF;
    run_instr(7'b0010111, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0);
    check("instret_wrap", {32'b0, bus.instret}, 64'd1);
    mon_en = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);
    bus.op = 7'b0100011;
    repeat (3) @(posedge clk);
    #1;
    check("mid_sw_state", {60'b0, bus.state}, 64'd5);
    check("mid_sw_memwrite", {62'b0, bus.MemWrite, bus.AdrSrc}, 64'd3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_memwrite", {63'b0, bus.MemWrite}, 64'd0);
    check("async_rst_state", {60'b0, bus.state}, 64'd0);
    check("async_rst_instret", {32'b0, bus.instret}, 64'd0);
    check("async_rst_flags", {60'b0, bus.retire, bus.illegal_op, bus.PCWrite, bus.IRWrite}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = '0;
    m_ret = 1'b0;
    m_ill = 1'b0;
    mon_en = 1'b1;
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);
    run_instr(7'b0010011, 3'd2, 1'b0, 1'b0);
    mon_en = 1'b0;
    check("final_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sits directly upstream of the datapath and drives every datapath control input: PC/IR/register/memory write enables, mux selects, ALU operation and immediate format. It decodes op/funct3/funct7b5 from the datapath's instruction register and uses the ALU Zero flag to resolve branches. It also provides retire/illegal status and a retired-instruction counter for debug.

## Interface
- No parameters.
- clk  in  1  core clock, same clock as the datapath flops
- reset  in  1  asynchronous, active-high reset
- op  in  7  opcode from the instruction register
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU result-is-zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = data, 10 = ALUResult
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ALUSrcB  out  2  B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ALUSrcA  out  2  A select: 00 = PC, 01 = OldPC, 10 = rs1 register, 11 = zero
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- RegWrite  out  1  register file write enable
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded
- instret  out  32  retired-instruction counter
- state  out  4  current FSM state, for debug

## Operation
- **Outputs are Moore-decoded** from state, with two exceptions:
  - ImmSrc is decoded from op alone: lw/OP-IMM/jalr → 000; sw → 001; branch → 010; jal → 011; lui/auipc → 100; anything else → 000.
  - PCWrite = PCUpdate | (state == BRANCH & taken).
- **Unlisted outputs are 0** in every state.
- **States, their encoding and their outputs:**
  - FETCH (0): AdrSrc 0, IRWrite 1, A 00, B 10, add, ResultSrc 10, PCUpdate 1.
  - DECODE (1): A 01, B 01, add; the branch/jump target is latched into ALUOut.
  - MEMADR (2): A 10, B 01, add.
  - MEMREAD (3): AdrSrc 1, ResultSrc 00.
  - MEMWB (4): ResultSrc 01, RegWrite 1.
  - MEMWRITE (5): AdrSrc 1, ResultSrc 00, MemWrite 1.
  - EXECR (6): A 10, B 00, ALUOp func.
  - EXECI (7): A 10, B 01, ALUOp func.
  - ALUWB (8): ResultSrc 00, RegWrite 1.
  - BRANCH (9): A 10, B 00, sub, ResultSrc 00.
  - JAL (10): A 01, B 10, add, ResultSrc 00, PCUpdate 1.
  - JALR (11): A 10, B 01, add.
  - LUI (12): A 11, B 01, add.
  - AUIPC (13): A 01, B 01, add.
- **DECODE transitions by op:**
  - 0000011 and 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other op → FETCH, with illegal_op pulsed.
- **Other transitions:**
  - FETCH → DECODE.
  - MEMADR → MEMREAD if op[5] = 0, else MEMWRITE.
  - MEMREAD → MEMWB → FETCH.
  - MEMWRITE → FETCH.
  - EXECR, EXECI, LUI, AUIPC → ALUWB → FETCH.
  - JALR → JAL → ALUWB.
  - BRANCH → FETCH.
  - Unused encodings 14–15 → FETCH.
- **Branch condition:** taken = (funct3 == 000 & Zero) | (funct3 == 001 & !Zero). Any other funct3 is never taken.
- **ALUOp func (EXECR/EXECI) decode by funct3:**
  - 000 → sub if op[5] & funct7b5, else add
  - 010 → slt
  - 110 → or
  - 111 → and
  - all others → add
- **Retire and instret:**
  - retire is registered: it is 1 in the cycle after leaving MEMWB, MEMWRITE, ALUWB or BRANCH.
  - instret increments by 1 on each retire and wraps from 0xFFFFFFFF to 0.
  - The illegal path never retires.

## Timing
- **Reset:** asynchronous and immediate.
  - state = FETCH; retire, illegal_op and instret are 0.
  - While reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. The remaining outputs show FETCH values.
- **Reset mid-instruction:** abandons the instruction. No write enable asserts after reset rises, and the instruction is not counted.
- **Cycles per instruction, counted from FETCH:**
  - lw 5, sw 4
  - R-type, I-type, lui, auipc 4
  - branch 3, jal 4, jalr 5
  - illegal 2
- **op/funct inputs** are sampled only in states after FETCH; values during FETCH are ignored except by the combinational ImmSrc.
- **illegal_op** is registered: it is 1 in the cycle after DECODE for an illegal op.

## Test plan
- **Reset:** assert reset mid-MEMWRITE → MemWrite drops to 0 in the same cycle; state = 0 and instret = 0. Deassert → state sequence 0, 1 begins.
- **lw then sw:**
  - op 0000011 → states 0, 1, 2, 3, 4, 0; ImmSrc 000; RegWrite only in state 4; retire pulses; instret = 1.
  - op 0100011 → states 0, 1, 2, 5, 0; MemWrite only in state 5, with AdrSrc = 1.
- **R-type:**
  - op 0110011, funct3 000, funct7b5 1 → ALUControl 001 in EXECR.
  - Same with op 0010011 → ALUControl 000 in EXECI.
  - funct3 110 → 011.
- **Branches:**
  - beq (funct3 000) with Zero = 1 → PCWrite = 1 in BRANCH.
  - bne (funct3 001) with Zero = 1 → PCWrite = 0.
  - funct3 100 → never taken.
- **Jumps and upper immediates:**
  - jalr → states 0, 1, 11, 10, 8, 0; PCWrite in states 0 and 10.
  - lui → ALUSrcA 11 and ImmSrc 100 in state 12.
- **Illegal and wrap:**
  - op 0000000 → states 0, 1, 0; illegal_op pulses once; instret unchanged.
  - Force instret to 0xFFFFFFFF, retire one instruction → instret = 0.
